shiftreg_ctrl: RTL and testbench

SHIFTREG_CTRL -- requirements
Module: shiftreg_ctrl

---
 rtl/shiftreg_ctrl.sv | 127 ++++++++++++
 tb/tb_shiftreg_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shiftreg_ctrl.sv
// Serial-to-parallel shift register with valid/ready handshakes, sticky overflow and optional even parity.
// Optional parity bit per word enabled by defining SHIFTREG_CTRL_PARITY_EN.
module shiftreg_ctrl #(
  parameter int DW = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out,
  output logic [$clog2(DW+2)-1:0]  count,
  output logic                     overflow,
  output logic                     perr
);

  localparam int CW = $clog2(DW+2);
  localparam logic [CW-1:0] LAST_DATA = CW'(DW - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PAR, FULL} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            accept;
  logic            handoff;

  assign in_ready  = (state_q != FULL) || out_ready;
  assign accept    = in_valid && in_ready;
  assign handoff   = (state_q == FULL) && out_ready;
  assign out_valid = (state_q == FULL);
  assign out       = sr_q;
  assign count     = cnt_q;
  assign overflow  = ovf_q;

`ifdef SHIFTREG_CTRL_PARITY_EN
  logic perr_q, perr_d;
  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q || (in_valid && !in_ready);
`ifdef SHIFTREG_CTRL_PARITY_EN
    perr_d  = perr_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          sr_d    = {sr_q[DW-2:0], in};
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (accept) begin
          sr_d  = {sr_q[DW-2:0], in};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_DATA) begin
`ifdef SHIFTREG_CTRL_PARITY_EN
            state_d = PAR;
`else
            state_d = FULL;
`endif
          end
        end
      end
      PAR: begin
`ifdef SHIFTREG_CTRL_PARITY_EN
        // Parity bit is checked against the held data but never enters the word.
        if (accept) begin
          cnt_d   = cnt_q + CW'(1);
          perr_d  = (^sr_q) ^ in;
          state_d = FULL;
        end
`else
        state_d = IDLE;
`endif
      end
      FULL: begin
        if (handoff) begin
`ifdef SHIFTREG_CTRL_PARITY_EN
          perr_d = 1'b0;
`endif
          // A bit accepted during handoff starts the next word immediately.
          if (accept) begin
            sr_d    = {sr_q[DW-2:0], in};
            cnt_d   = CW'(1);
            state_d = SHIFT;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef SHIFTREG_CTRL_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
`ifdef SHIFTREG_CTRL_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

endmodule

// File: tb/tb_shiftreg_ctrl.sv
// Directed bench for shiftreg_ctrl (DW=8) plus a randomized handshake stress against a bench-side model.
module tb_shiftreg_ctrl;
  localparam int DW = 8;
  localparam int CW = $clog2(DW+2);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_bit;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_word;
  logic [CW-1:0] count;
  logic          overflow;
  logic          perr;

  int n_tests = 0;
  int n_fail  = 0;

  shiftreg_ctrl #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in        (in_bit),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_word),
    .count     (count),
    .overflow  (overflow),
    .perr      (perr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    for (int i = DW-1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

`ifndef SHIFTREG_CTRL_PARITY_EN
  task automatic stress(input int cycles);
    logic          iv, d, ordy, exp_rdy, mfull, movf;
    logic [DW-1:0] mword;
    int            mcnt;
    mfull = 1'b0;
    movf  = 1'b0;
    mword = '0;
    mcnt  = 0;
    for (int c = 0; c < cycles; c++) begin
      iv        = 1'($urandom_range(0, 1));
      d         = 1'($urandom_range(0, 1));
      ordy      = 1'($urandom_range(0, 1));
      in_valid  = iv;
      in_bit    = d;
      out_ready = ordy;
      #1;
      exp_rdy = !mfull || ordy;
      check("stress_rdy", in_ready, exp_rdy);
      check("stress_vld", out_valid, mfull);
      if (iv && !exp_rdy) movf = 1'b1;
      if (mfull && ordy) begin
        check("stress_word", out_word, mword);
        mfull = 1'b0;
        mcnt  = 0;
      end
      if (iv && exp_rdy) begin
        mword = {mword[DW-2:0], d};
        mcnt++;
        if (mcnt == DW) mfull = 1'b1;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("stress_ovf", overflow, movf);
    check("stress_end_vld", out_valid, mfull);
  endtask
`endif

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    do_reset();

    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_out", out_word, 0);
    check("rst_overflow", overflow, 0);
    check("rst_perr", perr, 0);
    check("rst_in_ready", in_ready, 1);

`ifdef SHIFTREG_CTRL_PARITY_EN
    send_word(8'hB2);
    check("par_cnt_data", count, 8);
    check("par_vld_early", out_valid, 0);
    send_bit(1'b0);
    check("par_cnt_full", count, 9);
    check("par_vld", out_valid, 1);
    check("par_out_b2", out_word, 8'hB2);
    check("par_perr_b2", perr, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("par_handoff_vld", out_valid, 0);
    send_word(8'hB3);
    send_bit(1'b0);
    check("par_out_b3", out_word, 8'hB3);
    check("par_perr_b3", perr, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("par_perr_clr", perr, 0);
    check("par_cnt_clr", count, 0);
    check("par_ovf", overflow, 0);
`else
    // 1,0,1,1,0,0,1,0 -> 8'hB2
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("partial_count", count, 3);
    check("partial_vld", out_valid, 0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    check("word_vld", out_valid, 1);
    check("word_out", out_word, 8'hB2);
    check("word_count", count, 8);
    check("word_ovf", overflow, 0);

    // Offer bits while the word is held and not consumed
    in_valid = 1'b1;
    in_bit   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("held_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    check("held_ovf", overflow, 1);
    check("held_out", out_word, 8'hB2);
    check("held_count", count, 8);
    tick();
    tick();
    check("ovf_sticky", overflow, 1);

    // Handoff with simultaneous accept of the first bit of 8'hAB
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    #1;
    check("handoff_in_ready", in_ready, 1);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("handoff_vld", out_valid, 0);
    check("handoff_count", count, 1);
    for (int i = 6; i >= 0; i--) begin
      logic [7:0] w;
      w = 8'hAB;
      send_bit(w[i]);
    end
    check("nobubble_out", out_word, 8'hAB);
    check("nobubble_count", count, 8);
    check("nobubble_vld", out_valid, 1);

    // Handoff with no accept returns to idle
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_vld", out_valid, 0);
    check("idle_count", count, 0);
    check("idle_in_ready", in_ready, 1);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    check("idle_ordy_ignored", count, 0);
    check("idle_ordy_vld", out_valid, 0);

    // Mid-word reset, with a bit offered in the reset cycle
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    check("pre_rst_count", count, 5);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("midrst_count", count, 0);
    check("midrst_out", out_word, 0);
    check("midrst_ovf", overflow, 0);
    check("midrst_vld", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    send_word(8'h5C);
    check("fresh_out", out_word, 8'h5C);
    check("fresh_vld", out_valid, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    do_reset();
    stress(10000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
